spi_master: RTL and testbench

Synthesizable SPI master: the controller end of the SPI link that `spi_slave` implements. It serializes one `NBIT`-bit word per frame on MOSI and simultaneously deserializes MISO. It generates SCLK from the system clock through a programmable divider and frames each word with SS_N. It sits between system logic that issues `start`/`tx_data` and the 4-wire SPI bus (`spi_if`).

---
 rtl/spi_master.sv | 121 ++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one NBIT-bit frame per start, MSB first, SCLK derived from clk by CLK_DIV.
// Define SPI_MASTER_LOOPBACK_EN to feed the RX shifter from the internal mosi instead of the miso pin.
module spi_master #(
   parameter int NBIT    = 8,
   parameter int CPOL    = 0,
   parameter int CPHA    = 0,
   parameter int CLK_DIV = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [NBIT-1:0] tx_data,
   output logic            busy,
   output logic            tx_strobe,
   output logic [NBIT-1:0] rx_data,
   output logic            rx_strobe,
   output logic            ss_n,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso
);

   // state | meaning
   // IDLE  | bus idle, waiting for start
   // SETUP | ss_n asserted, first bit set up before edge 1
   // SHIFT | SCLK toggling, 2*NBIT edges
   // HOLD  | ss_n hold time after the last edge
   // GAP   | minimum ss_n high time before the next frame

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EW = $clog2(2 * NBIT);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   div_q;
   logic [EW-1:0]   edge_q;
   logic [NBIT-1:0] tx_sh, rx_sh, tx_next;
   logic            div_done, edge_last, sclk_edge, leading;
   logic            sample_now, drive_now, accept, frame_end, rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso;
   assign rx_bit      = mosi;
`else
   assign rx_bit      = miso;
`endif

   assign div_done   = (div_q == CW'(CLK_DIV - 1));
   assign edge_last  = (edge_q == EW'(2 * NBIT - 1));
   assign sclk_edge  = div_done && (state_q == SETUP || state_q == SHIFT);
   assign leading    = ~edge_q[0];
   assign sample_now = sclk_edge && ((CPHA == 0) ? leading : !leading);
   assign drive_now  = sclk_edge && ((CPHA == 0) ? (!leading && !edge_last) : leading);
   assign accept     = (state_q == IDLE) && start;
   assign frame_end  = (state_q == HOLD) && div_done;
   assign tx_next    = tx_sh << 1;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SETUP;
         SETUP:   if (div_done) state_d = SHIFT;
         SHIFT:   if (div_done && edge_last) state_d = HOLD;
         HOLD:    if (div_done) state_d = GAP;
         GAP:     if (div_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         edge_q    <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         rx_data   <= '0;
         tx_strobe <= 1'b0;
         rx_strobe <= 1'b0;
         ss_n      <= 1'b1;
         sclk      <= CPOL[0];
         mosi      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_strobe <= accept;
         rx_strobe <= frame_end;

         if (state_q == IDLE || div_done) div_q <= '0;
         else                             div_q <= div_q + CW'(1);

         if (state_q == IDLE)  edge_q <= '0;
         else if (sclk_edge)   edge_q <= edge_last ? '0 : edge_q + EW'(1);

         if (state_q == IDLE)  sclk <= CPOL[0];
         else if (sclk_edge)   sclk <= ~sclk;

         if (accept) begin
            tx_sh <= tx_data;
            rx_sh <= '0;
            ss_n  <= 1'b0;
            mosi  <= (CPHA == 0) ? tx_data[NBIT-1] : 1'b0;
         end else begin
            if (drive_now) begin
               tx_sh <= tx_next;
               // CPHA=0 already presents the current bit, so the next one comes from the shifted word
               mosi  <= (CPHA == 0) ? tx_next[NBIT-1] : tx_sh[NBIT-1];
            end
            if (sample_now) rx_sh <= (rx_sh << 1) | NBIT'(rx_bit);
            if (frame_end) begin
               ss_n    <= 1'b1;
               rx_data <= rx_sh;
               mosi    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: mode 0 and mode 3 instances, each with a behavioural SPI slave,
// scoreboarded frames, frame timing, busy/start handling and reset mid-frame.
module tb_spi_master;

   localparam int NBIT     = 8;
   localparam int CLK_DIV  = 4;
   localparam int T_RX     = 1 + (2 * NBIT + 1) * CLK_DIV;
   localparam int T_IDLE   = 1 + (2 * NBIT + 2) * CLK_DIV;
   localparam int GAP_HIGH = CLK_DIV + 1;   // GAP cycles plus the IDLE cycle that accepts the next start
   localparam logic [1:0] CPOL_M = 2'b10;
   localparam logic [1:0] CPHA_M = 2'b10;
`ifdef SPI_MASTER_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   typedef struct {
      int         inst;
      logic [7:0] rx;
      logic [7:0] tx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start[2], busy[2], tx_strobe[2], rx_strobe[2];
   logic       ss_n[2], sclk[2], mosi[2], miso[2];
   logic [7:0] tx_data[2], rx_data[2];

   int   errors = 0, checks = 0, cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_master #(.NBIT(NBIT), .CPOL(0), .CPHA(0), .CLK_DIV(CLK_DIV)) u_m0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx_data[0]), .busy(busy[0]),
      .tx_strobe(tx_strobe[0]), .rx_data(rx_data[0]), .rx_strobe(rx_strobe[0]),
      .ss_n(ss_n[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]));

   spi_master #(.NBIT(NBIT), .CPOL(1), .CPHA(1), .CLK_DIV(CLK_DIV)) u_m3 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx_data[1]), .busy(busy[1]),
      .tx_strobe(tx_strobe[1]), .rx_data(rx_data[1]), .rx_strobe(rx_strobe[1]),
      .ss_n(ss_n[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave model: shifts slv_word out on miso, captures mosi on its sampling edges
   logic [7:0] slv_word[2], slv_sh[2], slv_cap[2];
   logic       prev_sclk[2], prev_ss[2];

   always @(negedge clk) begin
      bit lead;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            miso[i]      = 1'($urandom_range(0, 1));
            prev_ss[i]   = 1'b1;
            prev_sclk[i] = CPOL_M[i];
         end else begin
            if (prev_ss[i] && !ss_n[i]) begin
               slv_sh[i]  = slv_word[i];
               slv_cap[i] = 8'h00;
               if (!CPHA_M[i]) begin
                  miso[i]   = slv_sh[i][7];
                  slv_sh[i] = slv_sh[i] << 1;
               end
            end else if (!ss_n[i] && sclk[i] !== prev_sclk[i]) begin
               lead = (sclk[i] !== CPOL_M[i]);
               if (lead == CPHA_M[i]) begin
                  miso[i]   = slv_sh[i][7];
                  slv_sh[i] = slv_sh[i] << 1;
               end else begin
                  slv_cap[i] = {slv_cap[i][6:0], mosi[i]};
               end
            end
            prev_ss[i]   = ss_n[i];
            prev_sclk[i] = sclk[i];
         end
      end
   end

   // Monitor: strobe counts/cycles, busy fall, ss_n high-run length, scoreboard pop
   int   tx_cnt[2] = '{0, 0}, rx_cnt[2] = '{0, 0};
   int   tx_cyc[2], rx_cyc[2], idle_cyc[2], hi_run[2] = '{0, 0}, last_hi_run[2] = '{0, 0};
   logic prev_busy[2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (tx_strobe[i]) begin
               tx_cnt[i]++;
               tx_cyc[i] = cyc;
            end
            if (rx_strobe[i]) begin
               rx_cnt[i]++;
               rx_cyc[i] = cyc;
               if (sb.size() == 0) chk("sb_unexpected_frame", 32'(i), 32'hFFFF);
               else begin
                  e = sb.pop_front();
                  chk("sb_inst", 32'(i), 32'(e.inst));
                  chk("rx_data", 32'(rx_data[i]), 32'(e.rx));
                  chk("mosi_word", 32'(slv_cap[i]), 32'(e.tx));
               end
            end
            if (prev_busy[i] && !busy[i]) idle_cyc[i] = cyc;
            if (ss_n[i]) hi_run[i]++;
            else begin
               if (hi_run[i] > 0) last_hi_run[i] = hi_run[i];
               hi_run[i] = 0;
            end
            prev_busy[i] = busy[i];
         end
      end
   end

   task automatic frame(input int i, input logic [7:0] tx, input logic [7:0] sw, output int t0);
      exp_t e;
      slv_word[i] = sw;
      @(negedge clk);
      tx_data[i] = tx;
      start[i]   = 1'b1;
      t0         = cyc;
      e.inst = i; e.rx = LB ? tx : sw; e.tx = tx;
      sb.push_back(e);
      @(negedge clk);
      start[i]   = 1'b0;
      tx_data[i] = 8'($urandom);
   endtask

   task automatic wait_idle(input int i, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         #1;
         if (!busy[i]) return;
      end
      chk("busy_timeout", 32'(i), 32'hFFFF);
   endtask

   initial begin
      int t0, base_tx, base_rx;
      bit seen;

      // reset with random inputs
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            start[i]   = 1'($urandom_range(0, 1));
            tx_data[i] = 8'($urandom);
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ss_n", 32'(ss_n[i]), 32'd1);
         chk("rst_sclk", 32'(sclk[i]), 32'(CPOL_M[i]));
         chk("rst_mosi", 32'(mosi[i]), 32'd0);
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_tx_strobe", 32'(tx_strobe[i]), 32'd0);
         chk("rst_rx_strobe", 32'(rx_strobe[i]), 32'd0);
         chk("rst_rx_data", 32'(rx_data[i]), 32'd0);
      end
      @(negedge clk);
      start[0] = 1'b0; start[1] = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // mode 0 frame with timing
      frame(0, 8'hA5, 8'h3C, t0);
      wait_idle(0, 200);
      chk("m0_tx_strobe_cycle", 32'(tx_cyc[0] - t0), 32'd1);
      chk("m0_rx_strobe_cycle", 32'(rx_cyc[0] - t0), 32'(T_RX));
      chk("m0_busy_fall_cycle", 32'(idle_cyc[0] - t0), 32'(T_IDLE));
      chk("m0_idle_sclk", 32'(sclk[0]), 32'd0);
      repeat (2) @(negedge clk);

      // mode 3 frame
      frame(1, 8'h81, 8'h7E, t0);
      #1;
      chk("m3_sclk_idle_high", 32'(sclk[1]), 32'd1);
      wait_idle(1, 200);
      chk("m3_rx_strobe_cycle", 32'(rx_cyc[1] - t0), 32'(T_RX));
      chk("m3_idle_sclk", 32'(sclk[1]), 32'd1);
      repeat (2) @(negedge clk);

      // start pulse while busy is ignored
      base_tx = tx_cnt[0]; base_rx = rx_cnt[0];
      frame(0, 8'hC3, 8'h96, t0);
      repeat (9) @(negedge clk);
      tx_data[0] = 8'hFF;
      start[0]   = 1'b1;
      @(negedge clk);
      start[0]   = 1'b0;
      wait_idle(0, 200);
      repeat (20) @(negedge clk);
      #1;
      chk("busy_start_tx_count", 32'(tx_cnt[0] - base_tx), 32'd1);
      chk("busy_start_rx_count", 32'(rx_cnt[0] - base_rx), 32'd1);
      chk("busy_start_idle", 32'(busy[0]), 32'd0);

      // start held high: back-to-back frames
      base_tx = tx_cnt[0]; base_rx = rx_cnt[0];
      slv_word[0] = 8'h5A;
      sb.push_back('{inst: 0, rx: (LB ? 8'h3C : 8'h5A), tx: 8'h3C});
      sb.push_back('{inst: 0, rx: (LB ? 8'h3C : 8'h5A), tx: 8'h3C});
      @(negedge clk);
      tx_data[0] = 8'h3C;
      start[0]   = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         #1;
         seen = (tx_cnt[0] - base_tx == 2);
      end
      start[0] = 1'b0;
      chk("held_start_second_frame", 32'(seen), 32'd1);
      chk("held_start_ss_high", 32'(last_hi_run[0]), 32'(GAP_HIGH));
      wait_idle(0, 200);
      chk("held_start_rx_count", 32'(rx_cnt[0] - base_rx), 32'd2);
      repeat (2) @(negedge clk);

      // reset after SCLK edge 5
      frame(0, 8'hF0, 8'h0F, t0);
      repeat (20) @(negedge clk);
      #1;
      chk("mid_edge5_sclk", 32'(sclk[0]), 32'd1);
      chk("mid_edge5_ss_n", 32'(ss_n[0]), 32'd0);
      base_rx = rx_cnt[0];
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ss_n", 32'(ss_n[0]), 32'd1);
      chk("mid_rst_sclk", 32'(sclk[0]), 32'd0);
      chk("mid_rst_mosi", 32'(mosi[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_rx_data", 32'(rx_data[0]), 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      #1;
      chk("mid_rst_no_rx_strobe", 32'(rx_cnt[0] - base_rx), 32'd0);
      frame(0, 8'h6B, 8'hD4, t0);
      wait_idle(0, 200);
      chk("post_rst_rx_count", 32'(rx_cnt[0] - base_rx), 32'd1);
      chk("post_rst_rx_cycle", 32'(rx_cyc[0] - t0), 32'(T_RX));

      // slave returns zero (loopback build expects the transmitted word)
      frame(0, 8'h5A, 8'h00, t0);
      wait_idle(0, 200);
      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
